// File: rtl/alu_operand_seq.sv
`default_nettype none
// ============================================================================
//  Module   : alu_operand_seq
//  Purpose  : Pushbutton-driven operand loader for the DE2 4-bit ALU.
//             Each debounced press latches A, B, then the opcode. The block
//             then fires one ALU operation and holds its result for display.
//             Define ALU_SEQ_CHAIN_EN so that a press in SHOW feeds the result
//             back into A and skips straight to loading B.
//  Revision : 1.0  initial release
// ============================================================================
module alu_operand_seq #(
    parameter int BIT      = 4,
    parameter int OPCODE   = 4,
    parameter int DEBOUNCE = 500000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              key_n,
    input  logic [BIT-1:0]    sw_data,
    input  logic [BIT-1:0]    alu_c,
    input  logic              alu_flag,
    output logic [BIT-1:0]    a,
    output logic [BIT-1:0]    b,
    output logic [OPCODE-1:0] op,
    output logic              valid,
    output logic [BIT-1:0]    res,
    output logic              res_flag,
    output logic [2:0]        state
);

    localparam int                c_CNT_W   = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;
    localparam logic [c_CNT_W-1:0] c_CNT_MAX = c_CNT_W'(DEBOUNCE - 1);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE = c_CNT_W'(1);

    typedef enum logic [2:0] {
        LOAD_A  = 3'd0,
        LOAD_B  = 3'd1,
        LOAD_OP = 3'd2,
        EXEC    = 3'd3,
        SHOW    = 3'd4
    } state_t;

    logic               r_sync1;
    logic               r_sync2;
    logic               r_acc;
    logic [c_CNT_W-1:0] r_cnt;
    logic               r_press;

    state_t             r_state;
    logic [BIT-1:0]     r_a;
    logic [BIT-1:0]     r_b;
    logic [OPCODE-1:0]  r_op;
    logic               r_valid;
    logic [BIT-1:0]     r_res;
    logic               r_res_flag;

    // Key conditioning. Idle level is high, so the flops reset to 1 and a
    // power-on with the key released produces no spurious press.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
            r_acc   <= 1'b1;
            r_cnt   <= '0;
            r_press <= 1'b0;
        end else begin
            r_sync1 <= key_n;
            r_sync2 <= r_sync1;
            r_press <= 1'b0;
            if (r_sync2 == r_acc) begin
                r_cnt <= '0;
            end else if (r_cnt == c_CNT_MAX) begin
                r_acc   <= r_sync2;
                r_cnt   <= '0;
                // Only a high-to-low acceptance is a press; release is silent.
                r_press <= r_acc;
            end else begin
                r_cnt <= r_cnt + c_CNT_ONE;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= LOAD_A;
            r_a        <= '0;
            r_b        <= '0;
            r_op       <= '0;
            r_valid    <= 1'b0;
            r_res      <= '0;
            r_res_flag <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            case (r_state)
                LOAD_A: begin
                    if (r_press) begin
                        r_a     <= sw_data;
                        r_state <= LOAD_B;
                    end
                end
                LOAD_B: begin
                    if (r_press) begin
                        r_b     <= sw_data;
                        r_state <= LOAD_OP;
                    end
                end
                LOAD_OP: begin
                    if (r_press) begin
                        r_op    <= sw_data[OPCODE-1:0];
                        r_valid <= 1'b1;
                        r_state <= EXEC;
                    end
                end
                EXEC: begin
                    // ALU is combinational on a/b/op, already stable here.
                    r_res      <= alu_c;
                    r_res_flag <= alu_flag;
                    r_state    <= SHOW;
                end
                SHOW: begin
                    if (r_press) begin
`ifdef ALU_SEQ_CHAIN_EN
                        r_a     <= r_res;
                        r_state <= LOAD_B;
`else
                        r_state <= LOAD_A;
`endif
                    end
                end
                default: begin
                    r_state <= LOAD_A;
                end
            endcase
        end
    end

    assign a        = r_a;
    assign b        = r_b;
    assign op       = r_op;
    assign valid    = r_valid;
    assign res      = r_res;
    assign res_flag = r_res_flag;
    assign state    = r_state;

endmodule
`default_nettype wire

// File: tb/tb_alu_operand_seq.sv
`default_nettype none
// ============================================================================
//  Module   : tb_alu_operand_seq
//  Purpose  : Self-checking bench for alu_operand_seq with a small ALU model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_alu_operand_seq;

    localparam int BIT      = 4;
    localparam int OPCODE   = 4;
    localparam int DEBOUNCE = 4;

    logic              clk = 1'b0;
    logic              reset;
    logic              key_n;
    logic [BIT-1:0]    sw_data;
    logic [BIT-1:0]    alu_c;
    logic              alu_flag;
    logic [BIT-1:0]    a;
    logic [BIT-1:0]    b;
    logic [OPCODE-1:0] op;
    logic              valid;
    logic [BIT-1:0]    res;
    logic              res_flag;
    logic [2:0]        state;

    int n_checks = 0;
    int n_fail   = 0;
    int valid_seen;

    alu_operand_seq #(.BIT(BIT), .OPCODE(OPCODE), .DEBOUNCE(DEBOUNCE)) dut (
        .clk(clk), .reset(reset), .key_n(key_n), .sw_data(sw_data),
        .alu_c(alu_c), .alu_flag(alu_flag), .a(a), .b(b), .op(op),
        .valid(valid), .res(res), .res_flag(res_flag), .state(state)
    );

    always #5 clk = ~clk;

    // Board ALU: 0 add (carry), 1 subtract (borrow), others AND (zero flag).
    always_comb begin
        alu_c    = '0;
        alu_flag = 1'b0;
        case (op)
            4'd0: {alu_flag, alu_c} = {1'b0, a} + {1'b0, b};
            4'd1: {alu_flag, alu_c} = {1'b0, a} - {1'b0, b};
            default: begin
                alu_c    = a & b;
                alu_flag = ((a & b) == 4'd0);
            end
        endcase
    end

    // Reference result computed with plain integer arithmetic.
    function automatic void model(input int ma, input int mb, input int mop,
                                  output int r, output int f);
        int s;
        if (mop == 0) begin
            s = ma + mb;
            r = s % 16;
            f = (s >= 16) ? 1 : 0;
        end else if (mop == 1) begin
            s = ma - mb;
            r = (s + 16) % 16;
            f = (s < 0) ? 1 : 0;
        end else begin
            r = ma & mb;
            f = (r == 0) ? 1 : 0;
        end
    endfunction

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic cycles_key(input logic lvl, input int n);
        key_n = lvl;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (valid) valid_seen++;
        end
    endtask

    // Full press: held low long enough to be accepted, then released.
    task automatic press(input logic [3:0] d);
        sw_data    = d;
        valid_seen = 0;
        cycles_key(1'b0, 12);
        cycles_key(1'b1, 12);
        sw_data = 4'($urandom);
    endtask

    task automatic do_reset();
        key_n = 1'b1;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic run_vec(input string tag, input int va, input int vb,
                           input int vop, input int er, input int ef);
        do_reset();
        press(4'(va));
        check({tag, " state after A"}, int'(state), 1);
        check({tag, " a"}, int'(a), va);
        press(4'(vb));
        check({tag, " state after B"}, int'(state), 2);
        check({tag, " b"}, int'(b), vb);
        press(4'(vop));
        check({tag, " valid pulses"}, valid_seen, 1);
        check({tag, " state SHOW"}, int'(state), 4);
        check({tag, " op"}, int'(op), vop);
        check({tag, " res"}, int'(res), er);
        check({tag, " res_flag"}, int'(res_flag), ef);
    endtask

    typedef struct {
        int va;
        int vb;
        int vop;
        int er;
        int ef;
    } vec_t;

    vec_t tbl[8];

    initial begin
        int r, f, ra, rb, rop;

        tbl[0] = '{5, 12, 0, 1, 1};
        tbl[1] = '{3, 4, 0, 7, 0};
        tbl[2] = '{15, 1, 0, 0, 1};
        tbl[3] = '{9, 9, 1, 0, 0};
        tbl[4] = '{2, 5, 1, 13, 1};
        tbl[5] = '{12, 10, 2, 8, 0};
        tbl[6] = '{5, 10, 2, 0, 1};
        tbl[7] = '{0, 0, 0, 0, 0};

        reset      = 1'b1;
        key_n      = 1'b1;
        sw_data    = 4'd0;
        valid_seen = 0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        check("reset a", int'(a), 0);
        check("reset b", int'(b), 0);
        check("reset op", int'(op), 0);
        check("reset res", int'(res), 0);
        check("reset res_flag", int'(res_flag), 0);
        check("reset valid", int'(valid), 0);
        check("reset state", int'(state), 0);

        cycles_key(1'b1, 20);
        check("idle key state", int'(state), 0);

        // Bounce shorter than the debounce window must not register.
        sw_data = 4'd7;
        cycles_key(1'b0, 3);
        cycles_key(1'b1, 12);
        check("bounce state", int'(state), 0);
        check("bounce a", int'(a), 0);
        cycles_key(1'b0, 10);
        cycles_key(1'b1, 12);
        check("held key single advance", int'(state), 1);
        check("held key a", int'(a), 7);

        // Reference sequence from the board bring-up: 5 + C.
        do_reset();
        press(4'd5);
        press(4'hC);
        press(4'd0);
        check("seq a", int'(a), 5);
        check("seq b", int'(b), 12);
        check("seq op", int'(op), 0);
        check("seq valid pulses", valid_seen, 1);
        check("seq res", int'(res), 1);
        check("seq res_flag", int'(res_flag), 1);
        check("seq state", int'(state), 4);

`ifdef ALU_SEQ_CHAIN_EN
        press(4'd9);
        check("chain a", int'(a), 1);
        check("chain state", int'(state), 1);
        press(4'd3);
        press(4'd0);
        check("chain res", int'(res), 4);
        check("chain res_flag", int'(res_flag), 0);
        check("chain state SHOW", int'(state), 4);
`else
        press(4'd9);
        check("show press state", int'(state), 0);
        check("show press a kept", int'(a), 5);
`endif

        // Asynchronous reset in LOAD_OP takes effect before any clock edge.
        do_reset();
        press(4'd6);
        press(4'd3);
        check("pre-reset state", int'(state), 2);
        reset = 1'b1;
        #1;
        check("async reset state", int'(state), 0);
        check("async reset a", int'(a), 0);
        check("async reset b", int'(b), 0);
        check("async reset op", int'(op), 0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 8; i++) begin
            model(tbl[i].va, tbl[i].vb, tbl[i].vop, r, f);
            check($sformatf("tbl%0d model", i), r * 2 + f, tbl[i].er * 2 + tbl[i].ef);
            run_vec($sformatf("tbl%0d", i), tbl[i].va, tbl[i].vb, tbl[i].vop,
                    tbl[i].er, tbl[i].ef);
        end

        for (int i = 0; i < 12; i++) begin
            ra  = int'($urandom_range(0, 15));
            rb  = int'($urandom_range(0, 15));
            rop = int'($urandom_range(0, 2));
            model(ra, rb, rop, r, f);
            run_vec($sformatf("rnd%0d", i), ra, rb, rop, r, f);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
